rng_word_packer: RTL and testbench
==================================

// Module: rng_word_packer
// PURPOSE
//  Downstream stage of the padlock entropy core: consumes the von Neumann corrected bit stream
//  (bit_in qualified by the core's done pulse) and packs accepted bits into WIDTH-bit words.
//  Buffers words in a DEPTH-entry FIFO with a valid/ready output for the host/UART side.
//  Adds a repetition-count health test that latches a failure on stuck entropy.
// PARAMETERS
//  WIDTH      8    bits per output word (>=2)
//  DEPTH      4    FIFO entries (power of 2, >=2)
//  REP_LIMIT  16   consecutive identical accepted bits that trip health_fail (>=2)
// PORTS
//  clk          in   1                  single clock; same domain as the corrector output
//  rst          in   1                  asynchronous, active-high reset
//  enable       in   1                  1 = accept bits; 0 = ignore bit_valid, hold partial word
//  clear        in   1                  sync clear of packer, FIFO, counters, flags (priority over all)
//  bit_in       in   1                  corrected entropy bit
//  bit_valid    in   1                  bit_in valid this cycle (corrector done; may assert back-to-back)
//  word_data    out  WIDTH              FIFO head word (first-word fall-through)
//  word_valid   out  1                  FIFO not empty
//  word_ready   in   1                  consumer takes word_data when word_valid & word_ready
//  fill_level   out  $clog2(DEPTH+1)    words currently in FIFO
//  drop_cnt     out  16                 completed words discarded on full FIFO; saturates at 16'hFFFF
//  overflow     out  1                  sticky: at least one word dropped
//  health_fail  out  1                  sticky: repetition test tripped
// BEHAVIOUR
//  - Reset (rst=1, async): all outputs 0; bit counter, run length, FIFO pointers 0; FSM = RUN.
//  - clear=1: same end state as reset, one cycle later; concurrent accept/pop that cycle discarded.
//  - FSM: RUN -> FAIL when the repetition test trips; FAIL -> RUN only via clear or rst.
//    health_fail = (state==FAIL). In FAIL, bit_valid is ignored; FIFO stays readable.
//  - Accept: bit accepted when state==RUN & enable & bit_valid.
//  - Packing: accepted bit written to word[bit_cnt]; first bit of a word lands in bit 0 (LSB-first).
//    bit_cnt increments mod WIDTH. When the WIDTH-th bit is accepted, the full word (incl. that bit)
//    is pushed in that same clock edge; word_valid rises the next cycle (latency 1 from last bit).
//  - Repetition test: run_len = 1 on first accepted bit, or when bit differs from previous accepted bit;
//    otherwise run_len+1. When run_len would reach REP_LIMIT: that bit is discarded (not packed, not
//    pushed), partial word and bit_cnt cleared, state -> FAIL. Previous-bit history ignores disabled cycles.
//  - FIFO: pop when word_valid & word_ready. Push succeeds if fill_level<DEPTH, or if full and a pop
//    occurs the same cycle (level unchanged). Otherwise word dropped: drop_cnt+1 (saturating), overflow=1.
//    Simultaneous push+pop on non-empty FIFO: level unchanged. Pointers wrap mod DEPTH.
//  - word_data is combinational from FIFO head; undefined (drive 0) when empty.
//  - enable low mid-word: bit_cnt, partial word, run_len held; packing resumes on re-enable.
//  - rst mid-word: partial bits lost; no word emitted.
// TESTING  (WIDTH=8, DEPTH=4, REP_LIMIT=16 unless noted)
//  1 Pack: accept 1,0,1,1,0,0,0,1 with word_ready=1 -> one word 8'h8D, word_valid high 1 cycle after
//    last bit, fill_level returns to 0 after pop; gaps in bit_valid do not change result.
//  2 Overflow: word_ready=0, push 6 words -> fill_level=4, drop_cnt=2, overflow=1; drain yields first
//    4 words in order; then full + simultaneous pop/push -> no drop, level stays 4.
//  3 Health: 15 accepted 1s -> health_fail=0; 16th 1 -> health_fail=1 next cycle, no word pushed,
//    later bits ignored; clear -> health_fail=0, fill_level=0, drop_cnt=0, packing restarts at bit 0.
//  4 Run reset: alternating 15 ones/1 zero for 64 bits -> health_fail stays 0, 8 words emitted.
//  5 Enable/reset: 4 bits, enable=0 with 10 bit_valid pulses, enable=1, 4 more bits -> one word of the
//    8 enabled bits only; separately assert rst after 5 bits -> all outputs 0 immediately, no word.
//  6 Saturation (force drop_cnt near max): drops beyond 16'hFFFF keep drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/rng_word_packer.sv
// Packs accepted von Neumann bits LSB-first into WIDTH-bit words, runs a repetition-count health test, and buffers the words in a FIFO.
// Latency: a completed word is visible on word_valid one cycle after its last bit; word_data is first-word fall-through.
// Backpressure: word_ready gates pops only. A word completed into a full FIFO without a same-cycle pop is dropped and counted.
module rng_word_packer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int REP_LIMIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       clear,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic [WIDTH-1:0]           word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic [15:0]                drop_cnt,
    output logic                       overflow,
    output logic                       health_fail
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic {S_RUN = 1'b0, S_FAIL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             run_ok;

    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] part_word, full_word;
    logic             prev_bit, have_prev;
    logic [RW-1:0]    run_len, run_next;
    logic             accept, rep_trip, pack, word_done;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             pop, push_ok, drop;

    // Health state register: leaves FAIL only through clear or rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    // Next state: a tripped repetition test latches FAIL
    always_comb begin
        state_nxt = state;
        if (clear)         state_nxt = S_RUN;
        else if (rep_trip) state_nxt = S_FAIL;
    end

    // State decode: bits are only accepted while RUN
    always_comb begin
        health_fail = (state == S_FAIL);
        run_ok      = (state == S_RUN);
    end

    // Accept qualification, run-length update and the word being assembled this cycle
    always_comb begin
        accept    = run_ok & enable & bit_valid & ~clear;
        run_next  = (have_prev && (bit_in == prev_bit)) ? run_len + RW'(1) : RW'(1);
        rep_trip  = accept && (run_next == RW'(REP_LIMIT));
        pack      = accept & ~rep_trip;
        word_done = pack && (bit_cnt == CW'(WIDTH - 1));
        full_word = part_word;
        full_word[bit_cnt] = bit_in;
    end

    // Packer state; the tripping bit is discarded along with the partial word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            part_word <= '0;
            prev_bit  <= 1'b0;
            have_prev <= 1'b0;
            run_len   <= '0;
        end else if (clear) begin
            bit_cnt   <= '0;
            part_word <= '0;
            prev_bit  <= 1'b0;
            have_prev <= 1'b0;
            run_len   <= '0;
        end else if (rep_trip) begin
            bit_cnt   <= '0;
            part_word <= '0;
        end else if (pack) begin
            prev_bit  <= bit_in;
            have_prev <= 1'b1;
            run_len   <= run_next;
            if (word_done) begin
                bit_cnt   <= '0;
                part_word <= '0;
            end else begin
                bit_cnt   <= bit_cnt + CW'(1);
                part_word <= full_word;
            end
        end
    end

    // A full FIFO still takes a word when the head leaves in the same cycle
    assign word_valid = (fill_level != '0);
    assign word_data  = word_valid ? mem[rd_ptr] : '0;
    assign pop        = word_valid & word_ready & ~clear;
    assign push_ok    = word_done & ((fill_level != LW'(DEPTH)) | pop);
    assign drop       = word_done & ~push_ok;

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= full_word;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   fill_level <= fill_level + LW'(1);
                2'b01:   fill_level <= fill_level - LW'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

    // Dropped-word accounting: saturating counter plus sticky flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rng_word_packer.sv
module tb_rng_word_packer;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 16;

    logic        clk = 1'b0;
    logic        rst, enable, clear, bit_in, bit_valid, word_ready;
    logic [7:0]  word_data;
    logic        word_valid;
    logic [2:0]  fill_level;
    logic [15:0] drop_cnt;
    logic        overflow, health_fail;

    int checks = 0;
    int errors = 0;

    // Reference model: word queue, list of pending bits, run counter, flags
    logic [7:0] m_fifo[$];
    bit         m_part[$];
    int         m_run;
    bit         m_have, m_prev, m_fail, m_ovf;
    int         m_drop;

    logic       lastb;

    rng_word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .bit_in(bit_in), .bit_valid(bit_valid),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .fill_level(fill_level), .drop_cnt(drop_cnt),
        .overflow(overflow), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_fifo.delete();
        m_part.delete();
        m_run  = 0;
        m_have = 0;
        m_prev = 0;
        m_fail = 0;
        m_ovf  = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit en, input bit rdy, input bit clr);
        bit         pop_now, push_now;
        int         r;
        logic [7:0] w;
        if (clr) begin
            model_reset();
            return;
        end
        pop_now  = (m_fifo.size() != 0) && rdy;
        push_now = 0;
        w        = '0;
        if (!m_fail && en && v) begin
            r = (m_have && m_prev == b) ? m_run + 1 : 1;
            if (r >= REP_LIMIT) begin
                m_fail = 1;
                m_part.delete();
            end else begin
                m_run  = r;
                m_have = 1;
                m_prev = b;
                m_part.push_back(b);
                if (m_part.size() == WIDTH) begin
                    for (int i = 0; i < WIDTH; i++) w[i] = m_part[i];
                    m_part.delete();
                    push_now = 1;
                end
            end
        end
        if (pop_now) void'(m_fifo.pop_front());
        if (push_now) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge
    task automatic cyc(input logic v, input logic b, input logic en, input logic rdy, input logic clr);
        bit_valid  = v;
        bit_in     = b;
        enable     = en;
        word_ready = rdy;
        clear      = clr;
        model_step(v, b, en, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] mk_word(input logic last);
        logic [7:0] w;
        w    = 8'($urandom);
        w[0] = ~last;
        return w;
    endfunction

    task automatic feed_word(input logic [7:0] w, input logic rdy);
        for (int i = 0; i < 8; i++) cyc(1'b1, w[i], 1'b1, rdy, 1'b0);
        lastb = w[7];
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (word_valid !== 1'b0)   begin errors++; $display("FAIL reset_word_valid got %0b exp 0", word_valid); end
        checks++; if (fill_level !== 3'd0)   begin errors++; $display("FAIL reset_fill_level got %0d exp 0", fill_level); end
        checks++; if (drop_cnt !== 16'd0)    begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        checks++; if (health_fail !== 1'b0)  begin errors++; $display("FAIL reset_health got %0b exp 0", health_fail); end
        checks++; if (word_data !== 8'h00)   begin errors++; $display("FAIL reset_word_data got %h exp 00", word_data); end
        rst = 1'b0;
    endtask

    task automatic test_pack();
        logic [7:0] p;
        p = 8'h8D;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, p[i], 1'b1, 1'b1, 1'b0);
            if (i < 7) begin
                checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL pack_early_valid bit %0d got %0b exp 0", i, word_valid); end
            end
            if (i < 7 && (i % 2 == 0)) cyc(1'b0, 1'($urandom), 1'b1, 1'b1, 1'b0);
        end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL pack_valid got %0b exp 1", word_valid); end
        checks++; if (word_data !== 8'h8D) begin errors++; $display("FAIL pack_data got %h exp 8d", word_data); end
        checks++; if (fill_level !== 3'd1) begin errors++; $display("FAIL pack_level got %0d exp 1", fill_level); end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL pack_level_after_pop got %0d exp 0", fill_level); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL pack_valid_after_pop got %0b exp 0", word_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_w[6];
        logic [7:0] w;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        lastb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_w[k] = mk_word(lastb);
            feed_word(exp_w[k], 1'b0);
        end
        checks++; if (fill_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", fill_level); end
        checks++; if (drop_cnt !== 16'd2)  begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt); end
        checks++; if (overflow !== 1'b1)   begin errors++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (word_data !== exp_w[k]) begin errors++; $display("FAIL ovf_drain_%0d got %h exp %h", k, word_data, exp_w[k]); end
            cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL ovf_drained_level got %0d exp 0", fill_level); end
        for (int k = 0; k < 4; k++) begin
            exp_w[k] = mk_word(lastb);
            feed_word(exp_w[k], 1'b0);
        end
        w = mk_word(lastb);
        for (int i = 0; i < 7; i++) cyc(1'b1, w[i], 1'b1, 1'b0, 1'b0);
        cyc(1'b1, w[7], 1'b1, 1'b1, 1'b0);
        lastb = w[7];
        word_ready = 1'b0;
        checks++; if (fill_level !== 3'd4)   begin errors++; $display("FAIL ovf_swap_level got %0d exp 4", fill_level); end
        checks++; if (drop_cnt !== 16'd2)    begin errors++; $display("FAIL ovf_swap_drop got %0d exp 2", drop_cnt); end
        checks++; if (word_data !== exp_w[1]) begin errors++; $display("FAIL ovf_swap_head got %h exp %h", word_data, exp_w[1]); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if ({fill_level, drop_cnt, overflow, word_valid} !== 21'd0)
            begin errors++; $display("FAIL ovf_clear got lvl %0d drop %0d ovf %0b vld %0b exp all 0", fill_level, drop_cnt, overflow, word_valid); end
    endtask

    task automatic test_health();
        logic [7:0] p;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_15 got %0b exp 0", health_fail); end
        checks++; if (fill_level !== 3'd1)  begin errors++; $display("FAIL health_15_level got %0d exp 1", fill_level); end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL health_16 got %0b exp 1", health_fail); end
        checks++; if (fill_level !== 3'd1)  begin errors++; $display("FAIL health_16_level got %0d exp 1", fill_level); end
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'(i % 2), 1'b1, 1'b0, 1'b0);
        checks++; if (fill_level !== 3'd1)  begin errors++; $display("FAIL health_ignored_level got %0d exp 1", fill_level); end
        checks++; if (word_data !== 8'hFF)  begin errors++; $display("FAIL health_head got %h exp ff", word_data); end
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (fill_level !== 3'd0)  begin errors++; $display("FAIL health_pop_in_fail got %0d exp 0", fill_level); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL health_clear got %0b exp 0", health_fail); end
        p = 8'h3A;
        for (int i = 0; i < 8; i++) cyc(1'b1, p[i], 1'b1, 1'b0, 1'b0);
        checks++; if (word_data !== 8'h3A || fill_level !== 3'd1)
            begin errors++; $display("FAIL health_restart got %h lvl %0d exp 3a lvl 1", word_data, fill_level); end
    endtask

    task automatic test_run_reset();
        int         pops;
        logic [7:0] e;
        pops = 0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 68; i++) begin
            if (word_valid && word_ready) begin
                e = (pops % 2 == 0) ? 8'hFF : 8'h7F;
                checks++; if (word_data !== e) begin errors++; $display("FAIL run_word_%0d got %h exp %h", pops, word_data, e); end
                pops++;
            end
            if (i < 64) cyc(1'b1, (i % 16 == 15) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0);
            else        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checks++; if (pops != 8)            begin errors++; $display("FAIL run_word_count got %0d exp 8", pops); end
        checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL run_health got %0b exp 0", health_fail); end
    endtask

    task automatic test_enable_reset();
        logic [7:0] a;
        a = 8'h35;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, a[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL en_hold_level got %0d exp 0", fill_level); end
        for (int i = 4; i < 8; i++) cyc(1'b1, a[i], 1'b1, 1'b0, 1'b0);
        checks++; if (fill_level !== 3'd1 || word_data !== 8'h35)
            begin errors++; $display("FAIL en_word got %h lvl %0d exp 35 lvl 1", word_data, fill_level); end
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'(i % 2), 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if ({word_valid, fill_level, drop_cnt, overflow, health_fail} !== 22'd0 || word_data !== 8'h00)
            begin errors++; $display("FAIL rst_async got vld %0b lvl %0d data %h exp all 0", word_valid, fill_level, word_data); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'(i % 2), 1'b1, 1'b0, 1'b0);
        checks++; if (fill_level !== 3'd0) begin errors++; $display("FAIL rst_partial_lost got %0d exp 0", fill_level); end
    endtask

    task automatic test_saturation();
        logic [15:0] e;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        lastb = 1'b0;
        for (int k = 0; k < 4; k++) feed_word(mk_word(lastb), 1'b0);
        force dut.drop_cnt = 16'hFFFD;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        release dut.drop_cnt;
        m_drop = 65533;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (drop_cnt !== 16'hFFFD) begin errors++; $display("FAIL sat_preload got %h exp fffd", drop_cnt); end
        for (int k = 0; k < 3; k++) begin
            feed_word(mk_word(lastb), 1'b0);
            e = (k == 0) ? 16'hFFFE : 16'hFFFF;
            checks++; if (drop_cnt !== e) begin errors++; $display("FAIL sat_drop_%0d got %h exp %h", k, drop_cnt, e); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %0b exp 1", overflow); end
    endtask

    task automatic test_random();
        logic        cur, v, en, rdy, clr;
        logic [21:0] exp_st;
        logic [7:0]  exp_d;
        cur = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 4000; n++) begin
            exp_st = {m_fifo.size() != 0, 3'(m_fifo.size()), 16'(m_drop), m_ovf, m_fail};
            exp_d  = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
            checks++; if ({word_valid, fill_level, drop_cnt, overflow, health_fail} !== exp_st)
                begin errors++; $display("FAIL rand_status cyc %0d got %h exp %h", n, {word_valid, fill_level, drop_cnt, overflow, health_fail}, exp_st); end
            checks++; if (word_data !== exp_d)
                begin errors++; $display("FAIL rand_data cyc %0d got %h exp %h", n, word_data, exp_d); end
            if ($urandom_range(0, 3) == 0) cur = ~cur;
            v   = ($urandom_range(0, 9) < 7);
            en  = ($urandom_range(0, 9) != 0);
            rdy = (n < 2000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 149) == 0);
            cyc(v, cur, en, rdy, clr);
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_overflow();
        test_health();
        test_run_reset();
        test_enable_reset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
